// File: rtl/apb_master.sv
// apb_master: single-beat command port to APB SETUP/ACCESS initiator with optional wait-state timeout
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam logic [16:0] TO = 17'(TIMEOUT_CYCLES);
    state_t      state;
    logic [15:0] cnt;
    logic [16:0] cnt_nx;
    logic        expire;
    assign cmd_ready = state == IDLE;
    assign cnt_nx    = {1'b0, cnt} + 17'd1;
    // the edge that would bring the count up to the threshold is the abort edge
    assign expire    = (TIMEOUT_CYCLES != 0) && (cnt_nx >= TO);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    pwrite <= cmd_write;
                    paddr  <= cmd_addr;
                    pwdata <= cmd_wdata;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: if (pready || expire) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= !pready;
                    rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    state     <= IDLE;
                end else begin
                    cnt <= (cnt == '1) ? cnt : cnt_nx[15:0];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector table plus hand-written back-to-back, timeout and reset sequences
module tb_apb_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    int tests = 0, fails = 0, pulses = 0;

    apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (rsp_valid) pulses++;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input vec_t v);
        cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.addr; cmd_wdata = v.wdata;
        pready = 1'b0; prdata = v.prdata;
        chk("idle_ready", {31'b0, cmd_ready}, 1);
        step();
        cmd_valid = 1'b0; cmd_addr = 32'h0BAD0BAD; cmd_wdata = 32'h0BADF00D; cmd_write = ~v.w;
        chk("setup_psel", {31'b0, psel}, 1);
        chk("setup_penable", {31'b0, penable}, 0);
        chk("setup_ready", {31'b0, cmd_ready}, 0);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwdata", pwdata, v.wdata);
        chk("setup_pwrite", {31'b0, pwrite}, {31'b0, v.w});
        pready = (v.waits == 0);
        step();
        for (int j = 0; j <= v.waits; j++) begin
            chk("access_psel", {31'b0, psel}, 1);
            chk("access_penable", {31'b0, penable}, 1);
            chk("access_rsp_valid", {31'b0, rsp_valid}, 0);
            chk("access_paddr", paddr, v.addr);
            pready = (j == v.waits);
            step();
        end
        chk("rsp_valid", {31'b0, rsp_valid}, 1);
        chk("rsp_err", {31'b0, rsp_err}, 0);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("done_psel", {30'b0, psel, penable}, 0);
        chk("done_ready", {31'b0, cmd_ready}, 1);
        chk("hold_paddr", paddr, v.addr);
        pready = 1'b0;
        step();
        chk("rsp_pulse_end", {31'b0, rsp_valid}, 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1234_5678, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 2, 32'h0000_FFFF, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h1111_1111, 0, 32'hCAFE_F00D, 32'hCAFE_F00D};
        // three stalls then pready on the 4th ACCESS edge: completion beats the timeout
        vecs[4] = '{1'b0, 32'h0000_0044, 32'h0, 3, 32'h0000_0001, 32'h0000_0001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus", {29'b0, psel, penable, pwrite}, 0);
        chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_ready", {31'b0, cmd_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) xfer(vecs[i]);

        // back-to-back: write then read with cmd_valid held throughout
        pulses = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'h1;
        pready = 1'b1; prdata = 32'h7777_0001;
        step();
        cmd_write = 1'b0; cmd_addr = 32'h104; cmd_wdata = 32'h0;
        chk("b2b_setup1", {30'b0, psel, penable}, 2);
        chk("b2b_paddr1", paddr, 32'h100);
        step();
        chk("b2b_access1", {30'b0, psel, penable}, 3);
        chk("b2b_pwdata1", pwdata, 32'h1);
        chk("b2b_pwrite1", {31'b0, pwrite}, 1);
        step();
        chk("b2b_rsp1", {31'b0, rsp_valid}, 1);
        chk("b2b_rdata1", rsp_rdata, 0);
        chk("b2b_ready", {31'b0, cmd_ready}, 1);
        step();
        cmd_valid = 1'b0;
        chk("b2b_setup2", {30'b0, psel, penable}, 2);
        chk("b2b_paddr2", paddr, 32'h104);
        chk("b2b_pwrite2", {31'b0, pwrite}, 0);
        step();
        chk("b2b_access2", {30'b0, psel, penable}, 3);
        chk("b2b_paddr2_hold", paddr, 32'h104);
        step();
        chk("b2b_rsp2", {31'b0, rsp_valid}, 1);
        chk("b2b_rdata2", rsp_rdata, 32'h7777_0001);
        pready = 1'b0;
        repeat (3) step();
        chk("b2b_pulses", pulses, 2);

        // timeout: pready stays low for 4 ACCESS cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; prdata = 32'hFFFF_FFFF;
        step();
        cmd_valid = 1'b0;
        step();
        for (int j = 0; j < 3; j++) begin
            chk("to_stall", {29'b0, psel, penable, rsp_valid}, 6);
            step();
        end
        chk("to_access4", {29'b0, psel, penable, rsp_valid}, 6);
        step();
        chk("to_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("to_rsp_err", {31'b0, rsp_err}, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_psel", {30'b0, psel, penable}, 0);
        step();
        chk("to_pulse_end", {30'b0, rsp_valid, rsp_err}, 0);
        xfer('{1'b0, 32'h300, 32'h0, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F});

        // reset while in ACCESS with pready low
        pulses = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h400; cmd_wdata = 32'h55;
        step();
        cmd_valid = 1'b0;
        step();
        chk("rst_mid_access", {30'b0, psel, penable}, 3);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_drop", {30'b0, psel, penable}, 0);
        chk("rst_mid_ready", {31'b0, cmd_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        chk("rst_mid_no_rsp", pulses, 0);
        chk("rst_mid_ready_after", {31'b0, cmd_ready}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
